evo_bank_ctrl: RTL

- Generation controller and N-bank frame-memory router for the Game-of-Life datapath.
- Owns the RST/RUN/PAUSE/STEP control FSM and the programmable evolution tick.
- Hands each generation to the round engine through a start/done handshake, and rotates source/destination banks only when a round has completed.
- Routes init/preset loader writes, engine traffic and VGA reads to NUM_BANKS dual-port RAMs (port A: engine/loader R/W; port B: VGA read-only).

---
 rtl/evo_pkg.sv | 19 +
 rtl/evo_tick_gen.sv | 34 +++
 rtl/evo_bank_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/evo_pkg.sv
// Shared types and constants for the Game-of-Life generation controller.
package evo_pkg;

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_STEP  = 2'd3
    } state_t;

    localparam int unsigned DEFAULT_BASE_PERIOD = 250000;
    localparam int unsigned SPEED_W             = 4;

    // Bank index width; never narrower than one bit.
    function automatic int unsigned bank_idx_w(input int unsigned num_banks);
        return (num_banks > 1) ? $clog2(num_banks) : 1;
    endfunction

endpackage

// File: rtl/evo_tick_gen.sv
// Programmable evolution tick: counts while enabled, fires and wraps at
// (BASE_PERIOD << speed_shift) - 1, holds while disabled.
module evo_tick_gen
    import evo_pkg::*;
#(
    parameter int unsigned BASE_PERIOD = DEFAULT_BASE_PERIOD,
    parameter int unsigned CNT_W       = 31
) (
    input  logic               clk_vga,
    input  logic               reset_btn,
    input  logic               en,
    input  logic               clr,
    input  logic [SPEED_W-1:0] speed_shift,
    output logic               tick_c
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] term;

    // Compared live, so a shorter period set mid-count wraps at once.
    assign term   = (CNT_W'(BASE_PERIOD) << speed_shift) - CNT_W'(1);
    assign tick_c = en & (cnt >= term);

    always_ff @(posedge clk_vga or posedge reset_btn) begin
        if (reset_btn) begin
            cnt <= '0;
        end else if (clr || tick_c) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/evo_bank_ctrl.sv
// Generation controller: RST/RUN/PAUSE/STEP FSM, round start/done handshake,
// source/destination bank rotation and frame-memory port routing.
module evo_bank_ctrl
    import evo_pkg::*;
#(
    parameter int unsigned NUM_BANKS   = 2,
    parameter int unsigned ADDR_W      = 24,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned BASE_PERIOD = DEFAULT_BASE_PERIOD,
    parameter int unsigned CNT_W       = 31
) (
    input  logic                             clk_vga,
    input  logic                             reset_btn,
    input  logic                             start,
    input  logic                             pause,
    input  logic                             clear,
    input  logic                             step,
    input  logic [SPEED_W-1:0]               speed_shift,
    input  logic                             init_busy,
    input  logic                             preset_busy,
    output logic                             init_start,
    input  logic [ADDR_W-1:0]                ld_addr,
    input  logic                             ld_wren,
    input  logic [DATA_W-1:0]                ld_wdata,
    output logic                             round_start,
    input  logic                             round_done,
    input  logic [ADDR_W-1:0]                eng_raddr,
    input  logic [ADDR_W-1:0]                eng_waddr,
    input  logic                             eng_wren,
    input  logic [DATA_W-1:0]                eng_wdata,
    output logic [DATA_W-1:0]                eng_rdata,
    input  logic [ADDR_W-1:0]                vga_addr,
    output logic [DATA_W-1:0]                vga_rdata,
    output logic [NUM_BANKS*ADDR_W-1:0]      bank_a_addr,
    output logic [NUM_BANKS-1:0]             bank_a_wren,
    output logic [NUM_BANKS*DATA_W-1:0]      bank_a_wdata,
    input  logic [NUM_BANKS*DATA_W-1:0]      bank_a_rdata,
    output logic [NUM_BANKS*ADDR_W-1:0]      bank_b_addr,
    input  logic [NUM_BANKS*DATA_W-1:0]      bank_b_rdata,
    output logic [1:0]                       state,
    output logic [bank_idx_w(NUM_BANKS)-1:0] src_bank,
    output logic [15:0]                      generation,
    output logic [7:0]                       overrun_cnt
);

    localparam int unsigned BW = bank_idx_w(NUM_BANKS);

    state_t        st, next_st;
    logic          round_busy;
    logic          init_done;
    logic [BW-1:0] src_d;
    logic [BW-1:0] dst_bank;
    logic          ld_busy, ld_mode;
    logic          tick_c, tick_issue_c, step_issue_c, swap_c;

    assign ld_busy      = init_busy | preset_busy;
    assign ld_mode      = (st == ST_RST) & ld_busy;
    assign tick_issue_c = tick_c & ~round_busy;
    assign swap_c       = round_done & round_busy;
    assign dst_bank     = (src_bank == BW'(NUM_BANKS - 1)) ? '0 : src_bank + BW'(1);
    assign state        = st;

    evo_tick_gen #(
        .BASE_PERIOD (BASE_PERIOD),
        .CNT_W       (CNT_W)
    ) u_tick (
        .clk_vga     (clk_vga),
        .reset_btn   (reset_btn),
        .en          (st == ST_RUN),
        .clr         (clear),
        .speed_shift (speed_shift),
        .tick_c      (tick_c)
    );

    always_ff @(posedge clk_vga or posedge reset_btn) begin
        if (reset_btn) begin
            st <= ST_RST;
        end else begin
            st <= next_st;
        end
    end

    // Command priority clear > pause > start > step; a pause pulse consumes the cycle.
    always_comb begin
        next_st      = st;
        step_issue_c = 1'b0;
        if (clear) begin
            next_st = ST_RST;
        end else begin
            unique case (st)
                ST_RST, ST_PAUSE: begin
                    if (!pause && !(st == ST_RST && ld_busy)) begin
                        if (start) begin
                            next_st = ST_RUN;
                        end else if (step) begin
                            next_st      = ST_STEP;
                            step_issue_c = ~round_busy;
                        end
                    end
                end
                ST_RUN: begin
                    if (pause) begin
                        next_st = ST_PAUSE;
                    end
                end
                ST_STEP: begin
                    if (swap_c) begin
                        next_st = ST_PAUSE;
                    end
                end
                default: next_st = ST_RST;
            endcase
        end
    end

    // Round handshake, bank rotation and counters.
    always_ff @(posedge clk_vga or posedge reset_btn) begin
        if (reset_btn) begin
            src_bank    <= '0;
            src_d       <= '0;
            generation  <= '0;
            overrun_cnt <= '0;
            round_busy  <= 1'b0;
            round_start <= 1'b0;
            init_start  <= 1'b0;
            init_done   <= 1'b0;
        end else begin
            init_done <= 1'b1;
            src_d     <= src_bank;
            if (clear) begin
                src_bank    <= '0;
                generation  <= '0;
                overrun_cnt <= '0;
                round_busy  <= 1'b0;
                round_start <= 1'b0;
                init_start  <= 1'b1;
            end else begin
                init_start  <= ~init_done;
                round_start <= tick_issue_c | step_issue_c;
                if (tick_issue_c || step_issue_c) begin
                    round_busy <= 1'b1;
                end else if (swap_c) begin
                    round_busy <= 1'b0;
                    src_bank   <= dst_bank;
                    generation <= generation + 16'd1;
                end
                if (tick_c && round_busy && overrun_cnt != 8'hFF) begin
                    overrun_cnt <= overrun_cnt + 8'd1;
                end
            end
        end
    end

    // Port A: loader broadcast in RST, otherwise engine read/write banks.
    always_comb begin
        bank_a_addr  = '0;
        bank_a_wren  = '0;
        bank_a_wdata = '0;
        bank_b_addr  = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            bank_b_addr[i*ADDR_W +: ADDR_W]  = vga_addr;
            bank_a_wdata[i*DATA_W +: DATA_W] = ld_mode ? ld_wdata : eng_wdata;
            if (ld_mode) begin
                bank_a_addr[i*ADDR_W +: ADDR_W] = ld_addr;
                bank_a_wren[i]                  = ld_wren;
            end else if (BW'(i) == src_bank) begin
                bank_a_addr[i*ADDR_W +: ADDR_W] = eng_raddr;
            end else if (BW'(i) == dst_bank) begin
                bank_a_addr[i*ADDR_W +: ADDR_W] = eng_waddr;
                bank_a_wren[i]                  = eng_wren & round_busy;
            end
        end
    end

    // Read muxes follow the bank that was source when the read was issued.
    always_comb begin
        eng_rdata = '0;
        vga_rdata = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (BW'(i) == src_d) begin
                eng_rdata = bank_a_rdata[i*DATA_W +: DATA_W];
                vga_rdata = bank_b_rdata[i*DATA_W +: DATA_W];
            end
        end
        if (ld_mode) begin
            vga_rdata = '0;
        end
    end

endmodule
